// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 memory path: load width encodings and the
// data-memory access FSM state encoding, reused by the decoder and stage-2 block.
package msrv32_pkg;

    localparam logic [1:0] LOAD_WIDTH_BYTE = 2'b00;
    localparam logic [1:0] LOAD_WIDTH_HALF = 2'b01;
    localparam logic [1:0] LOAD_WIDTH_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } dmem_state_e;

    // Width 2'b11 is handled as a word access everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            LOAD_WIDTH_BYTE: mis = 1'b0;
            LOAD_WIDTH_HALF: mis = lane[0];
            default:         mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Selects the addressed byte/half/word lane of a read word and sign- or
// zero-extends it to 32 bits for write-back.
module msrv32_load_align
    import msrv32_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_lane)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_data = i_rdata;
        case (i_size)
            LOAD_WIDTH_BYTE: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            LOAD_WIDTH_HALF: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default:         o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/msrv32_dmem_access_unit.sv
// Issues load/store requests on the data-memory bus (req/gnt/rvalid), stalls the
// pipeline while a transaction is open, and returns aligned load results.
module msrv32_dmem_access_unit
    import msrv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        mem_rd_req_in,
    input  logic        mem_wr_req_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wr_data_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [4:0]  rd_addr_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_wmask_out,
    input  logic        dmem_gnt_in,
    input  logic        dmem_rvalid_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        stall_out,
    output logic        load_valid_out,
    output logic [31:0] load_data_out,
    output logic [4:0]  load_rd_addr_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    dmem_state_e r_state;
    dmem_state_e w_state_nxt;

    logic [CNT_W-1:0] r_tmo_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [4:0]  r_rd;
    logic        r_load_valid;
    logic [31:0] r_load_data;
    logic [4:0]  r_load_rd;
    logic        r_misaligned;
    logic        r_bus_err;

    logic        w_idle;
    logic        w_req_present;
    logic        w_misaligned;
    logic        w_req_legal;
    logic        w_tmo_hit;
    logic        w_load_done;
    logic        w_tmo_evt;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata;
    logic [31:0] w_aligned;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_req_present = mem_rd_req_in | mem_wr_req_in;
    assign w_misaligned  = is_misaligned(load_size_in, addr_in[1:0]);
    assign w_req_legal   = w_idle & w_req_present & ~w_misaligned;
    assign w_tmo_hit     = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES));

    assign w_load_done = ((r_state == ST_REQ) & dmem_gnt_in & ~r_we & dmem_rvalid_in)
                       | ((r_state == ST_WAIT) & dmem_rvalid_in);
    assign w_tmo_evt   = ((r_state == ST_REQ) & ~dmem_gnt_in & w_tmo_hit)
                       | ((r_state == ST_WAIT) & ~dmem_rvalid_in & w_tmo_hit);

    always_ff @(posedge clk_in) begin
        if (reset_in) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_req_legal) w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (dmem_gnt_in) w_state_nxt = (r_we | dmem_rvalid_in) ? ST_IDLE : ST_WAIT;
                else if (w_tmo_hit) w_state_nxt = ST_IDLE;
            end
            ST_WAIT: if (dmem_rvalid_in | w_tmo_hit) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        dmem_req_out = (r_state == ST_REQ);
        stall_out    = ~w_idle | w_req_legal;
    end

    // Store lane generation; a store wins when both request flags are set.
    always_comb begin
        w_wmask = 4'b1111;
        w_wdata = wr_data_in;
        case (load_size_in)
            LOAD_WIDTH_BYTE: begin
                w_wmask = 4'b0001 << addr_in[1:0];
                w_wdata = {4{wr_data_in[7:0]}};
            end
            LOAD_WIDTH_HALF: begin
                w_wmask = 4'b0011 << addr_in[1:0];
                w_wdata = {2{wr_data_in[15:0]}};
            end
            default: begin
                w_wmask = 4'b1111;
                w_wdata = wr_data_in;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_rd       <= '0;
        end else if (w_req_legal) begin
            r_we       <= mem_wr_req_in;
            r_addr     <= addr_in;
            r_wdata    <= mem_wr_req_in ? w_wdata : 32'h0;
            r_wmask    <= mem_wr_req_in ? w_wmask : 4'b0000;
            r_size     <= load_size_in;
            r_unsigned <= load_unsigned_in;
            r_rd       <= rd_addr_in;
        end
    end

    // Idle clears the counter, so it always starts from zero on entry to REQ.
    always_ff @(posedge clk_in) begin
        if (reset_in || w_idle) r_tmo_cnt <= '0;
        else if (!w_tmo_hit)    r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end

    msrv32_load_align u_load_align (
        .i_rdata    (dmem_rdata_in),
        .i_lane     (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_aligned)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_load_valid <= 1'b0;
            r_load_data  <= '0;
            r_load_rd    <= '0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_load_valid <= w_load_done;
            r_misaligned <= w_idle & w_req_present & w_misaligned;
            r_bus_err    <= w_tmo_evt;
            if (w_load_done) begin
                r_load_data <= w_aligned;
                r_load_rd   <= r_rd;
            end
        end
    end

    assign dmem_we_out      = r_we;
    assign dmem_addr_out    = {r_addr[31:2], 2'b00};
    assign dmem_wdata_out   = r_wdata;
    assign dmem_wmask_out   = r_wmask;
    assign load_valid_out   = r_load_valid;
    assign load_data_out    = r_load_data;
    assign load_rd_addr_out = r_load_rd;
    assign misaligned_out   = r_misaligned;
    assign bus_err_out      = r_bus_err;

endmodule

// File: tb/tb_msrv32_dmem_access_unit.sv
// Directed bench for msrv32_dmem_access_unit: a vector table of loads/stores with
// hand-computed results, plus timeout and reset-in-WAIT sequences.
module tb_msrv32_dmem_access_unit;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        mem_rd_req_in, mem_wr_req_in;
    logic [31:0] addr_in, wr_data_in;
    logic [1:0]  load_size_in;
    logic        load_unsigned_in;
    logic [4:0]  rd_addr_in;
    logic        dmem_req_out, dmem_we_out;
    logic [31:0] dmem_addr_out, dmem_wdata_out;
    logic [3:0]  dmem_wmask_out;
    logic        dmem_gnt_in, dmem_rvalid_in;
    logic [31:0] dmem_rdata_in;
    logic        stall_out, load_valid_out;
    logic [31:0] load_data_out;
    logic [4:0]  load_rd_addr_out;
    logic        misaligned_out, bus_err_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    msrv32_dmem_access_unit #(.TIMEOUT_CYCLES(255)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .mem_rd_req_in(mem_rd_req_in), .mem_wr_req_in(mem_wr_req_in),
        .addr_in(addr_in), .wr_data_in(wr_data_in),
        .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
        .rd_addr_in(rd_addr_in),
        .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
        .dmem_addr_out(dmem_addr_out), .dmem_wdata_out(dmem_wdata_out),
        .dmem_wmask_out(dmem_wmask_out),
        .dmem_gnt_in(dmem_gnt_in), .dmem_rvalid_in(dmem_rvalid_in),
        .dmem_rdata_in(dmem_rdata_in),
        .stall_out(stall_out), .load_valid_out(load_valid_out),
        .load_data_out(load_data_out), .load_rd_addr_out(load_rd_addr_out),
        .misaligned_out(misaligned_out), .bus_err_out(bus_err_out)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        same;
        logic [4:0]  rdst;
        logic        mis;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_req"},   0, dmem_req_out, 0);
        chk({nm, "_we"},    0, dmem_we_out, 0);
        chk({nm, "_addr"},  0, dmem_addr_out, 0);
        chk({nm, "_wdata"}, 0, dmem_wdata_out, 0);
        chk({nm, "_wmask"}, 0, dmem_wmask_out, 0);
        chk({nm, "_stall"}, 0, stall_out, 0);
        chk({nm, "_lvalid"},0, load_valid_out, 0);
        chk({nm, "_ldata"}, 0, load_data_out, 0);
        chk({nm, "_lrd"},   0, load_rd_addr_out, 0);
        chk({nm, "_mis"},   0, misaligned_out, 0);
        chk({nm, "_berr"},  0, bus_err_out, 0);
    endtask

    task automatic present(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [1:0] sz, input logic u, input logic [31:0] wd,
                           input logic [4:0] rdst);
        mem_rd_req_in = rd; mem_wr_req_in = wr; addr_in = a; load_size_in = sz;
        load_unsigned_in = u; wr_data_in = wd; rd_addr_in = rdst;
    endtask

    task automatic run_vec(input vec_t v, input int i);
        logic [31:0] exp_addr;
        exp_addr = {v.addr[31:2], 2'b00};
        @(negedge clk_in);
        present(v.rd, v.wr, v.addr, v.size, v.uns, v.wdata, v.rdst);
        #1;
        chk("stall_on_request", i, stall_out, !v.mis);
        @(negedge clk_in);
        mem_rd_req_in = 1'b0; mem_wr_req_in = 1'b0;
        if (v.mis) begin
            chk("misaligned_pulse", i, misaligned_out, 1);
            chk("mis_no_req", i, dmem_req_out, 0);
            chk("mis_stall", i, stall_out, 0);
            @(negedge clk_in);
            chk("misaligned_one_cycle", i, misaligned_out, 0);
            chk("mis_no_req2", i, dmem_req_out, 0);
            return;
        end
        for (int k = 0; k < 2; k++) begin
            chk("req", i, dmem_req_out, 1);
            chk("we", i, dmem_we_out, v.wr);
            chk("addr", i, dmem_addr_out, exp_addr);
            chk("stall_req", i, stall_out, 1);
            if (v.wr) begin
                chk("wmask", i, dmem_wmask_out, v.exp_wmask);
                chk("wdata", i, dmem_wdata_out, v.exp_wdata);
            end
            if (k == 0) @(negedge clk_in);
        end
        dmem_gnt_in = 1'b1;
        if (!v.wr && v.same) begin
            dmem_rvalid_in = 1'b1; dmem_rdata_in = v.rdata;
        end
        @(negedge clk_in);
        dmem_gnt_in = 1'b0; dmem_rvalid_in = 1'b0; dmem_rdata_in = 32'h5A5A_A5A5;
        if (v.wr) begin
            chk("store_no_lvalid", i, load_valid_out, 0);
            chk("store_stall_drop", i, stall_out, 0);
            chk("store_req_drop", i, dmem_req_out, 0);
            @(negedge clk_in);
            chk("store_no_lvalid2", i, load_valid_out, 0);
            return;
        end
        if (!v.same) begin
            chk("wait_stall", i, stall_out, 1);
            chk("wait_no_req", i, dmem_req_out, 0);
            chk("wait_no_lvalid", i, load_valid_out, 0);
            dmem_rvalid_in = 1'b1; dmem_rdata_in = v.rdata;
            @(negedge clk_in);
            dmem_rvalid_in = 1'b0; dmem_rdata_in = 32'h5A5A_A5A5;
        end
        chk("load_valid", i, load_valid_out, 1);
        chk("load_data", i, load_data_out, v.exp_data);
        chk("load_rd", i, load_rd_addr_out, v.rdst);
        chk("load_stall_low", i, stall_out, 0);
        @(negedge clk_in);
        chk("load_valid_one_cycle", i, load_valid_out, 0);
        chk("load_data_hold", i, load_data_out, v.exp_data);
    endtask

    initial begin
        int n;
        int reqc;
        //          rd    wr    addr          sz     u     wdata         rdata         same  rd     mis   wmask    wdata         data
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_1003, 2'b00, 1'b0, 32'h0,        32'h80FF_FFFF, 1'b0, 5'd5,  1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_1001, 2'b00, 1'b1, 32'h0,        32'h1234_F678, 1'b0, 5'd6,  1'b0, 4'b0000, 32'h0,        32'h0000_00F6};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_4002, 2'b01, 1'b1, 32'h0,        32'h8001_ABCD, 1'b1, 5'd7,  1'b0, 4'b0000, 32'h0,        32'h0000_8001};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_4000, 2'b01, 1'b0, 32'h0,        32'h1234_F00F, 1'b0, 5'd8,  1'b0, 4'b0000, 32'h0,        32'hFFFF_F00F};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_5004, 2'b10, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0, 5'd9,  1'b0, 4'b0000, 32'h0,        32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_5008, 2'b11, 1'b1, 32'h0,        32'h0123_4567, 1'b0, 5'd10, 1'b0, 4'b0000, 32'h0,        32'h0123_4567};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_9000, 2'b00, 1'b0, 32'h0,        32'hFFFF_FF7F, 1'b1, 5'd11, 1'b0, 4'b0000, 32'h0,        32'h0000_007F};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_6001, 2'b00, 1'b0, 32'h0000_00A5, 32'h0,       1'b0, 5'd0,  1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_6003, 2'b00, 1'b0, 32'h1234_563C, 32'h0,       1'b0, 5'd0,  1'b0, 4'b1000, 32'h3C3C_3C3C, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_2002, 2'b01, 1'b0, 32'h0000_BEEF, 32'h0,       1'b0, 5'd0,  1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_7000, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0,       1'b0, 5'd0,  1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 32'h0000_8002, 2'b00, 1'b0, 32'h0000_0011, 32'h0,       1'b0, 5'd12, 1'b0, 4'b0100, 32'h1111_1111, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_3001, 2'b10, 1'b0, 32'h0,        32'h0,        1'b0, 5'd13, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_2003, 2'b01, 1'b0, 32'h0000_1234, 32'h0,       1'b0, 5'd0,  1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_4001, 2'b01, 1'b0, 32'h0,        32'h0,        1'b0, 5'd14, 1'b1, 4'b0000, 32'h0,        32'h0};

        reset_in = 1'b1;
        present(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 5'd0);
        dmem_gnt_in = 1'b0; dmem_rvalid_in = 1'b0; dmem_rdata_in = 32'h0;
        repeat (2) @(negedge clk_in);
        chk_all_zero("reset");
        reset_in = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Grant never arrives: the unit must give up after the timeout window.
        @(negedge clk_in);
        present(1'b1, 1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0, 5'd15);
        @(negedge clk_in);
        mem_rd_req_in = 1'b0;
        n = 1; reqc = 0;
        while (!bus_err_out && n < 400) begin
            if (dmem_req_out) reqc++;
            @(negedge clk_in);
            n++;
        end
        chk("timeout_cycle", 0, n, 257);
        chk("timeout_req_cycles", 0, reqc, 256);
        chk("timeout_stall_drop", 0, stall_out, 0);
        chk("timeout_req_drop", 0, dmem_req_out, 0);
        chk("timeout_no_lvalid", 0, load_valid_out, 0);
        dmem_rvalid_in = 1'b1; dmem_rdata_in = 32'h1111_2222;
        @(negedge clk_in);
        dmem_rvalid_in = 1'b0;
        chk("timeout_berr_one_cycle", 0, bus_err_out, 0);
        chk("late_rvalid_ignored", 0, load_valid_out, 0);
        chk("late_rvalid_data_hold", 0, load_data_out, 32'h0000_007F);

        // Reset while waiting for read data abandons the load.
        @(negedge clk_in);
        present(1'b1, 1'b0, 32'h0000_A000, 2'b10, 1'b0, 32'h0, 5'd3);
        @(negedge clk_in);
        mem_rd_req_in = 1'b0;
        chk("rst_seq_req", 0, dmem_req_out, 1);
        dmem_gnt_in = 1'b1;
        @(negedge clk_in);
        dmem_gnt_in = 1'b0;
        chk("rst_seq_wait_stall", 0, stall_out, 1);
        reset_in = 1'b1;
        @(negedge clk_in);
        reset_in = 1'b0;
        chk_all_zero("reset_in_wait");
        dmem_rvalid_in = 1'b1; dmem_rdata_in = 32'h3333_4444;
        @(negedge clk_in);
        dmem_rvalid_in = 1'b0;
        chk("post_reset_no_lvalid", 0, load_valid_out, 0);
        chk("post_reset_ldata", 0, load_data_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
